// File: rtl/alu_op_sequencer.sv
// Operand capture and one-hot op sequencing for the 8-bit ALU.
// Steps through NUM_OPS ops on step button edges or on a dwell timer.
module alu_op_sequencer #(
  parameter int unsigned NUM_OPS      = 9,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned WRAP         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw_a,
  input  logic [7:0]  sw_b,
  input  logic        load,
  input  logic        step,
  input  logic        auto,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [15:0] op_code,
  output logic [3:0]  op_index,
  output logic        busy,
  output logic        result_valid,
  output logic        done
);

  localparam int unsigned CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX   = 4'(NUM_OPS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, step_q, auto_q;
  logic [7:0]    a_d, b_d;
  logic [15:0]   op_code_d;
  logic [3:0]    op_index_d;
  logic          busy_d, done_d, rv_d;
  logic          load_edge, step_edge, adv, upd;

  assign load_edge = load & ~load_q;
  assign step_edge = step & ~step_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output logic; upd marks any change of op_code/a/b
  always_comb begin
    state_d    = state_q;
    a_d        = a;
    b_d        = b;
    op_code_d  = op_code;
    op_index_d = op_index;
    busy_d     = busy;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    adv        = 1'b0;
    upd        = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_code_d  = 16'h0000;
        op_index_d = 4'd0;
        busy_d     = 1'b0;
        cnt_d      = '0;
        if (load_edge) begin
          a_d        = sw_a;
          b_d        = sw_b;
          op_code_d  = 16'h0001;
          busy_d     = 1'b1;
          upd        = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        adv = auto ? (cnt_q == DWELL_LAST) : step_edge;
        if (load_edge) begin
          a_d        = sw_a;
          b_d        = sw_b;
          op_index_d = 4'd0;
          op_code_d  = 16'h0001;
          cnt_d      = '0;
          upd        = 1'b1;
        end else if (adv) begin
          cnt_d = '0;
          upd   = 1'b1;
          if (op_index != LAST_IDX) begin
            op_index_d = op_index + 4'd1;
            op_code_d  = op_code << 1;
          end else begin
            done_d     = 1'b1;
            op_index_d = 4'd0;
            if (WRAP != 0) begin
              op_code_d = 16'h0001;
            end else begin
              op_code_d = 16'h0000;
              busy_d    = 1'b0;
              state_d   = S_IDLE;
            end
          end
        end else if (auto != auto_q) begin
          cnt_d = '0;
        end else if (auto) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // ALU samples during the cycle after an update; its outputs are good one cycle later
    rv_d = (state_d == S_RUN) && !upd;
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a            <= 8'h00;
      b            <= 8'h00;
      op_code      <= 16'h0000;
      op_index     <= 4'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      cnt_q        <= '0;
      load_q       <= 1'b1;
      step_q       <= 1'b1;
      auto_q       <= 1'b0;
    end else begin
      a            <= a_d;
      b            <= b_d;
      op_code      <= op_code_d;
      op_index     <= op_index_d;
      busy         <= busy_d;
      result_valid <= rv_d;
      done         <= done_d;
      cnt_q        <= cnt_d;
      load_q       <= load;
      step_q       <= step;
      auto_q       <= auto;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer; two instances (WRAP=1 and WRAP=0)
// are compared every cycle against a behavioural model.
module tb_alu_op_sequencer;

  localparam int DWELL = 4;
  localparam int NOPS  = 9;

  logic clk = 1'b0;
  logic rst_n, load, step, auto;
  logic [7:0] sw_a, sw_b;

  logic [7:0]  a1, b1, a0, b0;
  logic [15:0] op1, op0;
  logic [3:0]  idx1, idx0;
  logic        busy1, busy0, rv1, rv0, done1, done0;

  alu_op_sequencer #(.NUM_OPS(NOPS), .DWELL_CYCLES(DWELL), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b), .load(load), .step(step),
    .auto(auto), .a(a1), .b(b1), .op_code(op1), .op_index(idx1), .busy(busy1),
    .result_valid(rv1), .done(done1));

  alu_op_sequencer #(.NUM_OPS(NOPS), .DWELL_CYCLES(DWELL), .WRAP(0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b), .load(load), .step(step),
    .auto(auto), .a(a0), .b(b0), .op_code(op0), .op_index(idx0), .busy(busy0),
    .result_valid(rv0), .done(done0));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Behavioural model: index 1 is WRAP=1, index 0 is WRAP=0
  bit       m_run [2];
  int       m_idx [2];
  int       m_held[2];
  bit [7:0] m_a   [2];
  bit [7:0] m_b   [2];
  bit       m_done[2];
  bit       m_rv  [2];
  bit       ld_q, st_q, au_q;

  task automatic model_step();
    bit le, se, adv, upd;
    le = load && !ld_q;
    se = step && !st_q;
    for (int w = 0; w < 2; w++) begin
      m_done[w] = 0;
      upd = 0;
      if (!rst_n) begin
        m_run[w] = 0; m_idx[w] = 0; m_held[w] = 0;
        m_a[w] = 0; m_b[w] = 0; m_rv[w] = 0;
        continue;
      end
      if (!m_run[w]) begin
        if (le) begin
          m_a[w] = sw_a; m_b[w] = sw_b; m_idx[w] = 0; m_held[w] = 0;
          m_run[w] = 1; upd = 1;
        end
      end else begin
        adv = auto ? (m_held[w] == DWELL - 1) : se;
        if (le) begin
          m_a[w] = sw_a; m_b[w] = sw_b; m_idx[w] = 0; m_held[w] = 0; upd = 1;
        end else if (adv) begin
          upd = 1; m_held[w] = 0;
          if (m_idx[w] < NOPS - 1) m_idx[w]++;
          else begin
            m_done[w] = 1; m_idx[w] = 0;
            if (w == 0) m_run[w] = 0;
          end
        end else if (auto != au_q) m_held[w] = 0;
        else if (auto) m_held[w]++;
        else m_held[w] = 0;
      end
      m_rv[w] = m_run[w] && !upd;
    end
    ld_q = rst_n ? load : 1'b1;
    st_q = rst_n ? step : 1'b1;
    au_q = auto;
  endtask

  function automatic logic [31:0] exp_op(input int w);
    logic [15:0] v;
    v = m_run[w] ? 16'(1 << m_idx[w]) : 16'h0000;
    return 32'(v);
  endfunction

  task automatic compare();
    chk("w1_a", 32'(a1), 32'(m_a[1]));
    chk("w1_b", 32'(b1), 32'(m_b[1]));
    chk("w1_op_code", 32'(op1), exp_op(1));
    chk("w1_op_index", 32'(idx1), 32'(m_idx[1]));
    chk("w1_busy", 32'(busy1), 32'(m_run[1]));
    chk("w1_result_valid", 32'(rv1), 32'(m_rv[1]));
    chk("w1_done", 32'(done1), 32'(m_done[1]));
    chk("w0_a", 32'(a0), 32'(m_a[0]));
    chk("w0_b", 32'(b0), 32'(m_b[0]));
    chk("w0_op_code", 32'(op0), exp_op(0));
    chk("w0_op_index", 32'(idx0), 32'(m_idx[0]));
    chk("w0_busy", 32'(busy0), 32'(m_run[0]));
    chk("w0_result_valid", 32'(rv0), 32'(m_rv[0]));
    chk("w0_done", 32'(done0), 32'(m_done[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; load = 1'b1; step = 1'b1; auto = 1'b0; sw_a = 8'h00; sw_b = 8'h00;
    ld_q = 1'b1; st_q = 1'b1; au_q = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("held_buttons_idle_busy", 32'(busy1), 32'd0);
    chk("held_buttons_idle_op", 32'(op1), 32'd0);

    // Load press captures operands
    sw_a = 8'h3C; sw_b = 8'h0F; load = 1'b0;
    tick();
    load = 1'b1;
    tick();
    chk("load_a", 32'(a1), 32'h3C);
    chk("load_b", 32'(b1), 32'h0F);
    chk("load_op", 32'(op1), 32'h0001);
    chk("load_busy", 32'(busy1), 32'd1);
    chk("load_rv_low", 32'(rv1), 32'd0);
    tick();
    chk("load_rv_high", 32'(rv1), 32'd1);

    // Switches move without a load
    sw_a = 8'hFF; sw_b = 8'hEE;
    repeat (2) tick();
    chk("sw_ignored_a", 32'(a1), 32'h3C);
    chk("sw_ignored_rv", 32'(rv1), 32'd1);

    // Manual walk through all ops plus the wrap/end edge
    for (int i = 0; i < NOPS; i++) begin
      step = 1'b0; tick();
      step = 1'b1; tick();
      if (i == NOPS - 2) chk("manual_last_op", 32'(op1), 32'h0100);
    end
    chk("wrap_op", 32'(op1), 32'h0001);
    chk("wrap_done", 32'(done1), 32'd1);
    chk("end_busy", 32'(busy0), 32'd0);
    chk("end_op", 32'(op0), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done1), 32'd0);

    // Load and step on the same edge at op_index 5
    for (int i = 0; i < 5; i++) begin
      step = 1'b0; tick();
      step = 1'b1; tick();
    end
    chk("at_idx5", 32'(idx1), 32'd5);
    sw_a = 8'hA5; sw_b = 8'h5A; load = 1'b0; step = 1'b0;
    tick();
    load = 1'b1; step = 1'b1;
    tick();
    chk("collide_op", 32'(op1), 32'h0001);
    chk("collide_a", 32'(a1), 32'hA5);
    chk("collide_done", 32'(done1), 32'd0);

    // Auto mode with step chatter and an auto toggle mid-dwell
    auto = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step = ~step;
      tick();
    end
    auto = 1'b0; tick();
    auto = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Reset pulse while running at op_index 7
    guard = 0;
    while (m_idx[1] != 7 && guard < 100) begin
      tick();
      guard++;
    end
    chk("reach_idx7", 32'(idx1), 32'd7);
    rst_n = 1'b0; tick();
    chk("midrun_reset_op", 32'(op1), 32'd0);
    chk("midrun_reset_busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) load = ~load;
      if ($urandom_range(2) == 0) step = ~step;
      if ($urandom_range(149) == 0) auto = ~auto;
      sw_a = 8'($urandom);
      sw_b = 8'($urandom);
      rst_n = ($urandom_range(399) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control stage directly upstream of the 8-bit ALU. Captures operands from board switches and drives the ALU's one-hot 16-bit op_code, stepping through the nine defined operations (sum … XNOR) either on button presses or automatically on a dwell timer. Also flags when the ALU's registered outputs (1-cycle latency) reflect the current op, so the display stage can latch them.

Parameters:
NUM_OPS, 9, number of implemented ALU ops; op index runs 0..NUM_OPS-1, op_code = 1 << index
DWELL_CYCLES, 50_000_000, clock cycles each op is held in auto mode (min 2)
WRAP, 1, 1 = restart at index 0 after last op; 0 = return to IDLE after last op

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
sw_a  in  8  operand A switches (already synchronised)
sw_b  in  8  operand B switches (already synchronised)
load  in  1  button level (synchronised, debounced); rising edge captures operands and starts sequence
step  in  1  button level (synchronised, debounced); rising edge advances op in manual mode
auto  in  1  1 = advance on dwell timer, 0 = advance on step edge
a  out  8  registered operand A to ALU
b  out  8  registered operand B to ALU
op_code  out  16  one-hot op select to ALU; all-zero when idle
op_index  out  4  current op index (0..NUM_OPS-1), 0 when idle
busy  out  1  high in RUN state
result_valid  out  1  ALU outputs correspond to current op_code/a/b
done  out  1  one-cycle pulse when the last op is left (wrap or end)

Behaviour:
- Reset (rst_n low at rising edge): state IDLE, a=0, b=0, op_code=0, op_index=0, busy=0, result_valid=0, done=0, dwell counter=0, load/step edge registers=1 (a button held through reset does not produce an edge). Reset overrides all other inputs, including mid-sequence.
- Edge detect: load_edge = load & ~load_q, step_edge = step & ~step_q; _q registered every cycle.
- States: IDLE, RUN.
- IDLE: op_code=0. On load_edge -> capture a<=sw_a, b<=sw_b, op_index<=0, op_code<=16'h0001, busy<=1, go RUN. step_edge ignored.
- RUN, advance condition: manual (auto=0): step_edge; auto (auto=1): dwell counter == DWELL_CYCLES-1.
- On advance with op_index < NUM_OPS-1: op_index+1, op_code shifted left 1, dwell counter<=0.
- On advance with op_index == NUM_OPS-1: done pulses 1 cycle; WRAP=1 -> op_index<=0, op_code<=16'h0001, stay RUN; WRAP=0 -> op_index<=0, op_code<=0, busy<=0, go IDLE.
- Dwell counter: width $clog2(DWELL_CYCLES); increments each RUN cycle while auto=1; held at 0 while auto=0 and in IDLE; cleared on any advance, load_edge, or change of auto.
- load_edge in RUN: recapture operands, op_index<=0, op_code<=16'h0001, counter<=0; takes priority over a same-cycle advance (no done pulse).
- Operands change only on load_edge; sw_a/sw_b ignored otherwise.
- result_valid: if op_code/a/b update at the edge ending cycle N, result_valid=0 in cycle N+1 (ALU sampling), 1 from N+2 until the next update. Always 0 in IDLE.
- Invariant: op_code is all-zero or exactly one bit set, bit position == op_index; bits 15..NUM_OPS never set.

Test Plan:
- Reset with load and step held high, release rst_n -> no transition; IDLE, op_code=0, busy=0; then release/press load with sw_a=8'h3C, sw_b=8'h0F -> a=3C, b=0F, op_code=0001, busy=1; result_valid 0 for one cycle then 1.
- Manual mode: 8 step edges -> op_code walks 0002..0100, op_index 1..8; 9th edge -> done pulse 1 cycle, op_code=0001 (WRAP=1); with WRAP=0 -> op_code=0, busy=0, IDLE.
- Auto mode, DWELL_CYCLES=4: op_code changes exactly every 4 cycles; step edges ignored; toggling auto mid-dwell restarts count.
- load_edge and step_edge same cycle at op_index=5 -> op_index=0, new operands captured, no done, op_code=0001.
- rst_n low for one cycle at op_index=7 in auto mode -> next cycle all outputs at reset values, counter=0.
- Switch sw_a changes during RUN without load -> a unchanged, result_valid stays 1.
